// File: rtl/bcd_to_bin_convertor_pkg.sv
// bcd_conv_pkg: shared constants, FSM state type and width helper for the
// packed-BCD to binary convertor.
package bcd_conv_pkg;

  localparam int       DIGIT_W       = 4;
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  localparam logic [3:0] ADJ_THRESH    = 4'd8;
  localparam logic [3:0] ADJ_VAL       = 4'd3;

  typedef enum logic {IDLE = 1'b0, CONV = 1'b1} state_t;

  // ceil(log2(10**digits)): binary width that holds the largest BCD value,
  // which is also the number of shift steps the engine needs.
  function automatic int calc_bin_w(input int digits);
    longint p;
    int     w;
    p = 1;
    w = 0;
    for (int i = 0; i < digits; i++) p = p * 10;
    for (int i = 0; i < 40; i++)
      if ((longint'(1) << i) < p) w = i + 1;
    return w;
  endfunction

endpackage

// File: rtl/bcd_to_bin_convertor_if.sv
// Request/response bundle for bcd_to_bin_convertor.
//   start, bcd_in                 : requester -> convertor
//   bin_result, done, busy, err   : convertor -> requester
interface bcd_to_bin_convertor_if #(parameter int DIGITS = 3);
  import bcd_conv_pkg::*;

  localparam int BIN_W = calc_bin_w(DIGITS);

  logic                        start;
  logic [DIGIT_W*DIGITS-1:0]   bcd_in;
  logic [BIN_W-1:0]            bin_result;
  logic                        done;
  logic                        busy;
  logic                        err;

  modport master (output start, bcd_in, input bin_result, done, busy, err);
  modport slave  (input start, bcd_in, output bin_result, done, busy, err);
endinterface

// File: rtl/bcd_to_bin_convertor_digit_adjust.sv
// bcd_digit_adjust: one step of reverse double-dabble correction for a
// single BCD digit. After a right shift a digit that picked up the 8 weight
// from its upper neighbour holds 8+x but should hold 5+x, so subtract 3.
//   din  : shifted 4-bit digit field
//   dout : corrected digit field
module bcd_digit_adjust
  import bcd_conv_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= ADJ_THRESH) ? din - ADJ_VAL : din;
endmodule

// File: rtl/bcd_to_bin_convertor.sv
// bcd_to_bin_convertor: iterative packed-BCD to unsigned binary converter.
// One shift/adjust step per clock; BIN_W steps per conversion, result
// returned with a one-cycle done pulse. Operands with a digit > 9 are
// rejected in one cycle with err=1 and bin_result=0.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of bcd_to_bin_convertor_if
//              (start/bcd_in in; bin_result/done/busy/err out)
module bcd_to_bin_convertor
  import bcd_conv_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  bcd_to_bin_convertor_if.slave   bus
);
  localparam int BIN_W = calc_bin_w(DIGITS);
  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

  state_t                   state, state_nxt;
  logic [SR_W-1:0]          sr;
  logic [SR_W-1:0]          shifted;
  logic [DIGITS-1:0][3:0]   adj_dig;
  logic [SR_W-1:0]          nxt;
  logic [CNT_W-1:0]         cnt;
  logic [DIGITS-1:0]        dig_bad;
  logic                     any_bad;
  logic                     last_step;

  // Shift, then correct every BCD digit field of the shifted word.
  assign shifted = sr >> 1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_digit_adjust u_adj (
      .din  (shifted[BIN_W + DIGIT_W*g +: DIGIT_W]),
      .dout (adj_dig[g])
    );
    assign dig_bad[g] = bus.bcd_in[DIGIT_W*g +: DIGIT_W] > BCD_MAX_DIGIT;
  end

  assign nxt       = {adj_dig, shifted[BIN_W-1:0]};
  assign any_bad   = |dig_bad;
  assign last_step = (cnt == LAST);

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start && !any_bad) state_nxt = CONV;
      CONV: if (last_step)             state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.busy = (state == CONV);
  end

  // Datapath and result registers. done defaults low so it only pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr             <= '0;
      cnt            <= '0;
      bus.bin_result <= '0;
      bus.done       <= 1'b0;
      bus.err        <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          if (any_bad) begin
            bus.err        <= 1'b1;
            bus.done       <= 1'b1;
            bus.bin_result <= '0;
          end else begin
            sr      <= {bus.bcd_in, {BIN_W{1'b0}}};
            bus.err <= 1'b0;
            cnt     <= '0;
          end
        end
        CONV: begin
          sr  <= nxt;
          cnt <= cnt + 1'b1;
          if (last_step) begin
            bus.bin_result <= nxt[BIN_W-1:0];
            bus.done       <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
